demux8_1_wide_buf: RTL and testbench



---
 rtl/demux8_1_wide_buf.sv | 58 +++++
 tb/tb_demux8_1_wide_buf.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux8_1_wide_buf.sv
// demux8_1_wide_buf: buffered 1:8 valid/ready distributor with a small FIFO per lane
module demux8_1_wide_buf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data [8],
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [7:0] full;
  logic       push_ok;
  assign in_ready = reset & ~full[in_sel];
  assign push_ok  = in_valid & in_ready;
  assign busy     = |out_valid;
  for (genvar l = 0; l < 8; l++) begin : g_lane
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] hold;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;
    assign push          = push_ok && (in_sel == 3'(l));
    assign pop           = out_valid[l] & out_ready[l];
    assign full[l]       = count == CW'(DEPTH);
    assign out_valid[l]  = count != '0;
    assign out_data[l]   = out_valid[l] ? mem[rd_ptr] : hold;
    // pointers, occupancy and the last-popped word shown while the lane is empty
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        hold   <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
          hold   <= mem[rd_ptr];
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
    // lane storage; contents are only visible through a nonzero count
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
    end
  end
endmodule

// File: tb/tb_demux8_1_wide_buf.sv
// tb_demux8_1_wide_buf: randomized self-checking bench with a per-lane queue model
module tb_demux8_1_wide_buf;
  localparam int WIDTH = 64;
  localparam int DEPTH = 2;
  typedef logic [WIDTH-1:0] word_q_t [$];

  logic             clk = 0;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data [8];
  logic [7:0]       out_valid;
  logic [7:0]       out_ready;
  logic             busy;

  int checks = 0;
  int failures = 0;
  word_q_t q [8];
  word_q_t sent [8];
  word_q_t got [8];
  logic [WIDTH-1:0] hold [8];

  demux8_1_wide_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] exp_data(int i);
    return q[i].size() != 0 ? q[i][0] : hold[i];
  endfunction

  function automatic logic [7:0] exp_valid();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = q[i].size() != 0;
    return v;
  endfunction

  function automatic logic exp_ready();
    return reset && q[in_sel].size() < DEPTH;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      q[i].delete();
      hold[i] = '0;
    end
  endtask

  task automatic step();
    logic [7:0]       pop;
    logic             push;
    logic [2:0]       s;
    logic [WIDTH-1:0] d;
    s = in_sel;
    d = in_data;
    push = in_valid && reset && q[s].size() < DEPTH;
    for (int i = 0; i < 8; i++) pop[i] = out_ready[i] && q[i].size() != 0;
    @(posedge clk);
    for (int i = 0; i < 8; i++) if (pop[i]) hold[i] = q[i].pop_front();
    if (push) q[s].push_back(d);
    #1;
  endtask

  task automatic test_reset();
    reset = 0; in_valid = 0; in_sel = 0; in_data = '0; out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    model_clear();
    in_valid = 1; in_sel = 1; in_data = 64'h55;
    step();
    in_sel = 3;
    #3;
    reset = 0;
    model_clear();
    #1;
    checks++;
    if (out_valid !== 8'h00) begin
      failures++;
      $display("FAIL reset_out_valid got=%h want=00", out_valid);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=0", in_ready);
    end
    in_valid = 0;
    @(posedge clk);
    #2;
    reset = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_in_ready got=%b want=1", in_ready);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL release_busy got=%b want=0", busy);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_data[i] !== '0) begin
        failures++;
        $display("FAIL release_out_data lane=%0d got=%h want=0", i, out_data[i]);
      end
    end
  endtask

  task automatic test_single();
    in_valid = 1; in_sel = 5; in_data = 64'hDEAD_BEEF_0000_0005; out_ready = '0;
    step();
    in_valid = 0;
    checks++;
    if (out_valid !== 8'b0010_0000) begin
      failures++;
      $display("FAIL single_valid got=%b want=00100000", out_valid);
    end
    checks++;
    if (out_data[5] !== 64'hDEAD_BEEF_0000_0005) begin
      failures++;
      $display("FAIL single_data got=%h want=deadbeef00000005", out_data[5]);
    end
    out_ready = 8'b0010_0000;
    step();
    out_ready = '0;
    checks++;
    if (out_valid[5] !== 1'b0) begin
      failures++;
      $display("FAIL single_pop_valid got=%b want=0", out_valid[5]);
    end
    checks++;
    if (out_data[5] !== 64'hDEAD_BEEF_0000_0005) begin
      failures++;
      $display("FAIL single_hold_data got=%h want=deadbeef00000005", out_data[5]);
    end
  endtask

  task automatic test_fill();
    out_ready = '0;
    in_valid = 1; in_sel = 2; in_data = 64'h1;
    step();
    in_data = 64'h2;
    step();
    in_valid = 0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_ready_lane2 got=%b want=0", in_ready);
    end
    in_sel = 4;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL fill_ready_lane4 got=%b want=1", in_ready);
    end
    in_valid = 1; in_sel = 2; in_data = 64'h3;
    step();
    checks++;
    if (out_valid !== 8'b0000_0100 || out_valid !== exp_valid()) begin
      failures++;
      $display("FAIL fill_third_valid got=%b want=00000100", out_valid);
    end
    checks++;
    if (out_data[2] !== 64'h1) begin
      failures++;
      $display("FAIL fill_head got=%h want=1", out_data[2]);
    end
  endtask

  task automatic test_full_pop();
    logic [WIDTH-1:0] want [3];
    want[0] = 64'h2; want[1] = 64'h3; want[2] = 64'h3;
    out_ready = 8'b0000_0100;
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 1) in_valid = 0;
      checks++;
      if (out_data[2] !== want[k] || out_data[2] !== exp_data(2)) begin
        failures++;
        $display("FAIL full_pop_data step=%0d got=%h want=%h", k, out_data[2], want[k]);
      end
    end
    checks++;
    if (out_valid[2] !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_drained got=%b want=0", out_valid[2]);
    end
    out_ready = '0;
  endtask

  task automatic test_stream();
    out_ready = 8'h80;
    in_valid = 1; in_sel = 7;
    for (int k = 0; k < 16; k++) begin
      in_data = WIDTH'(k);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_ready k=%0d got=%b want=1", k, in_ready);
      end
      step();
      checks++;
      if (out_data[7] !== WIDTH'(k) || out_valid[7] !== 1'b1) begin
        failures++;
        $display("FAIL stream_data k=%0d got=%h/%b want=%h/1", k, out_data[7], out_valid[7], k);
      end
    end
    in_valid = 0;
    step();
    out_ready = '0;
  endtask

  task automatic test_round_robin();
    int stall;
    for (int i = 0; i < 8; i++) begin
      sent[i].delete();
      got[i].delete();
    end
    for (int n = 0; n < 128; n++) begin
      in_valid = 1;
      in_sel = 3'(n % 8);
      in_data = {$urandom, $urandom};
      stall = 0;
      forever begin
        out_ready = 8'($urandom);
        #1;
        checks++;
        if (in_ready !== exp_ready()) begin
          failures++;
          $display("FAIL rr_ready n=%0d got=%b want=%b", n, in_ready, exp_ready());
        end
        checks++;
        if (out_valid !== exp_valid()) begin
          failures++;
          $display("FAIL rr_valid n=%0d got=%b want=%b", n, out_valid, exp_valid());
        end
        for (int i = 0; i < 8; i++) begin
          checks++;
          if (out_data[i] !== exp_data(i)) begin
            failures++;
            $display("FAIL rr_data n=%0d lane=%0d got=%h want=%h", n, i, out_data[i], exp_data(i));
          end
          if (out_valid[i] && out_ready[i]) got[i].push_back(out_data[i]);
        end
        if (exp_ready()) begin
          sent[in_sel].push_back(in_data);
          step();
          break;
        end
        step();
        stall++;
        if (stall > 100) begin
          checks++;
          failures++;
          $display("FAIL rr_stall_timeout n=%0d", n);
          break;
        end
      end
    end
    in_valid = 0;
    out_ready = 8'hFF;
    for (int c = 0; c < 20 && busy; c++) begin
      #1;
      for (int i = 0; i < 8; i++) if (out_valid[i]) got[i].push_back(out_data[i]);
      step();
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rr_busy_end got=%b want=0", busy);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] != sent[i]) begin
        failures++;
        $display("FAIL rr_scoreboard lane=%0d got_n=%0d want_n=%0d", i, got[i].size(), sent[i].size());
      end
    end
    out_ready = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_stream();
    test_round_robin();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
